// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings for the data-memory port arbiter: FSM states and the
// ResultSrc value that selects load data in the MEM stage.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCpuBusy = 2'd1,
    StDbgBusy = 2'd2
  } state_e;

  localparam logic [1:0] ResultMem = 2'b01;

  // Decode helper for the MEM-stage load qualifier (ResultSrcM == RESULT_MEM).
  function automatic logic is_mem_load(input logic [1:0] result_src);
    return result_src == ResultMem;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of CPU MEM-stage, debug requester and data-memory signals around the
// arbiter; the arbiter takes the slave view, requesters/memory the master view.
interface dmem_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);

  logic          cpu_rd_i;
  logic          cpu_wr_i;
  logic [AW-1:0] cpu_addr_i;
  logic [DW-1:0] cpu_wdata_i;
  logic [DW-1:0] cpu_rdata_o;
  logic          cpu_stall_o;

  logic          dbg_req_i;
  logic          dbg_we_i;
  logic [AW-1:0] dbg_addr_i;
  logic [DW-1:0] dbg_wdata_i;
  logic          dbg_gnt_o;
  logic [DW-1:0] dbg_rdata_o;
  logic          dbg_done_o;

  logic          mem_req_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata_i;
  logic          mem_ready_i;

  modport slave (
    input  cpu_rd_i, cpu_wr_i, cpu_addr_i, cpu_wdata_i,
    output cpu_rdata_o, cpu_stall_o,
    input  dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
    output dbg_gnt_o, dbg_rdata_o, dbg_done_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i, mem_ready_i
  );

  modport master (
    output cpu_rd_i, cpu_wr_i, cpu_addr_i, cpu_wdata_i,
    input  cpu_rdata_o, cpu_stall_o,
    output dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
    input  dbg_gnt_o, dbg_rdata_o, dbg_done_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i, mem_ready_i
  );

endinterface

// File: rtl/dmem_starve_cnt.sv
// Saturating wait counter for the debug requester; limit_hit_o flags that the
// requester has waited long enough to take priority over the CPU.
module dmem_starve_cnt #(
  parameter int unsigned Limit = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic inc_i,
  input  logic clr_i,
  output logic limit_hit_o
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != 8'(Limit))) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign limit_hit_o = (cnt_q == 8'(Limit));

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single data-memory port between the MEM stage and a debug/DMA
// requester, stalling the pipeline until a variable-latency access completes.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned AW           = 32,
  parameter int unsigned DW           = 32,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input logic          clk,
  input logic          reset_n,
  dmem_arbiter_if.slave bus
);

  state_e state_q, state_d;

  logic          cpu_acc, force_dbg, limit_hit;
  logic          cpu_take, dbg_take, dbg_finish;
  logic          mem_req_q, mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic          dbg_gnt_q, dbg_done_q;
  logic [DW-1:0] dbg_rdata_q;

  assign cpu_acc   = bus.cpu_rd_i | bus.cpu_wr_i;
  assign force_dbg = bus.dbg_req_i & limit_hit;

  always_comb begin
    state_d  = state_q;
    cpu_take = 1'b0;
    dbg_take = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cpu_acc && !force_dbg) begin
          cpu_take = 1'b1;
          state_d  = StCpuBusy;
        end else if (bus.dbg_req_i) begin
          dbg_take = 1'b1;
          state_d  = StDbgBusy;
        end
      end
      StCpuBusy: if (bus.mem_ready_i) state_d = StIdle;
      StDbgBusy: if (bus.mem_ready_i) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  assign dbg_finish = (state_q == StDbgBusy) && bus.mem_ready_i;

  dmem_starve_cnt #(
    .Limit(STARVE_LIMIT)
  ) u_starve_cnt (
    .clk        (clk),
    .reset_n    (reset_n),
    .inc_i      (bus.dbg_req_i & ~dbg_take),
    .clr_i      (dbg_take | ~bus.dbg_req_i),
    .limit_hit_o(limit_hit)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Address/data/we registers keep their last value while idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      dbg_gnt_q   <= 1'b0;
      dbg_done_q  <= 1'b0;
      dbg_rdata_q <= '0;
    end else begin
      dbg_gnt_q  <= dbg_take;
      dbg_done_q <= dbg_finish;
      if (cpu_take) begin
        mem_req_q   <= 1'b1;
        mem_we_q    <= bus.cpu_wr_i;
        mem_addr_q  <= bus.cpu_addr_i;
        mem_wdata_q <= bus.cpu_wdata_i;
      end else if (dbg_take) begin
        mem_req_q   <= 1'b1;
        mem_we_q    <= bus.dbg_we_i;
        mem_addr_q  <= bus.dbg_addr_i;
        mem_wdata_q <= bus.dbg_wdata_i;
      end else if ((state_q != StIdle) && bus.mem_ready_i) begin
        mem_req_q <= 1'b0;
      end
      if (dbg_finish) begin
        dbg_rdata_q <= bus.mem_rdata_i;
      end
    end
  end

  // Releasing on the ready cycle lets the pipeline advance on that same edge.
  assign bus.cpu_stall_o = cpu_acc & ~((state_q == StCpuBusy) & bus.mem_ready_i);
  assign bus.cpu_rdata_o = bus.mem_rdata_i;
  assign bus.mem_req_o   = mem_req_q;
  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_wdata_o = mem_wdata_q;
  assign bus.dbg_gnt_o   = dbg_gnt_q;
  assign bus.dbg_done_o  = dbg_done_q;
  assign bus.dbg_rdata_o = dbg_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed plan steps plus random CPU/debug traffic
// checked against a transaction-level memory model.
module tb_dmem_arbiter;

  localparam int unsigned AW     = 32;
  localparam int unsigned DW     = 32;
  localparam int unsigned STARVE = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  logic [31:0] mem_model [logic [31:0]];

  dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  dmem_arbiter #(
    .AW          (AW),
    .DW          (DW),
    .STARVE_LIMIT(STARVE)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a ^ 32'h5A5A_0F0F;
  endfunction

  task automatic quiet_inputs();
    bus.cpu_rd_i    = 1'b0;
    bus.cpu_wr_i    = 1'b0;
    bus.cpu_addr_i  = $urandom;
    bus.cpu_wdata_i = $urandom;
    bus.dbg_req_i   = 1'b0;
    bus.dbg_we_i    = 1'b0;
    bus.dbg_addr_i  = $urandom;
    bus.dbg_wdata_i = $urandom;
    bus.mem_ready_i = 1'b0;
    bus.mem_rdata_i = $urandom;
  endtask

  // One MEM-stage access: the stalled IDLE cycle, lat BUSY cycles, then an idle cycle.
  task automatic cpu_access(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input int lat);
    @(negedge clk);
    bus.cpu_rd_i    = rd;
    bus.cpu_wr_i    = wr;
    bus.cpu_addr_i  = addr;
    bus.cpu_wdata_i = wdata;
    bus.mem_ready_i = 1'b0;
    #1;
    chk("cpu_first_stall", bus.cpu_stall_o, 1);
    chk("cpu_first_req", bus.mem_req_o, 0);
    for (int i = 1; i <= lat; i++) begin
      @(negedge clk);
      bus.mem_ready_i = (i == lat);
      bus.mem_rdata_i = (i == lat && !wr) ? model_rd(addr) : $urandom;
      #1;
      chk("cpu_req", bus.mem_req_o, 1);
      chk("cpu_we", bus.mem_we_o, wr);
      chk("cpu_addr", bus.mem_addr_o, addr);
      if (wr) chk("cpu_wdata", bus.mem_wdata_o, wdata);
      chk("cpu_stall", bus.cpu_stall_o, i != lat);
      if (i == lat && !wr) chk("cpu_rdata", bus.cpu_rdata_o, model_rd(addr));
    end
    if (wr) mem_model[addr] = wdata;
    @(negedge clk);
    bus.cpu_rd_i    = 1'b0;
    bus.cpu_wr_i    = 1'b0;
    bus.mem_ready_i = 1'($urandom_range(0, 1));  // must be ignored while idle
    #1;
    chk("cpu_after_req", bus.mem_req_o, 0);
    chk("cpu_after_stall", bus.cpu_stall_o, 0);
    chk("cpu_after_addr_held", bus.mem_addr_o, addr);
  endtask

  task automatic dbg_access(input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input int lat);
    logic [31:0] exp_rd;
    exp_rd = we ? $urandom : model_rd(addr);
    @(negedge clk);
    bus.dbg_req_i   = 1'b1;
    bus.dbg_we_i    = we;
    bus.dbg_addr_i  = addr;
    bus.dbg_wdata_i = wdata;
    bus.mem_ready_i = 1'b0;
    #1;
    chk("dbg_first_gnt", bus.dbg_gnt_o, 0);
    chk("dbg_first_req", bus.mem_req_o, 0);
    for (int i = 1; i <= lat; i++) begin
      @(negedge clk);
      bus.mem_ready_i = (i == lat);
      bus.mem_rdata_i = (i == lat) ? exp_rd : $urandom;
      #1;
      chk("dbg_req", bus.mem_req_o, 1);
      chk("dbg_we", bus.mem_we_o, we);
      chk("dbg_addr", bus.mem_addr_o, addr);
      if (we) chk("dbg_wdata", bus.mem_wdata_o, wdata);
      chk("dbg_gnt", bus.dbg_gnt_o, i == 1);
      chk("dbg_done_early", bus.dbg_done_o, 0);
      chk("dbg_no_cpu_stall", bus.cpu_stall_o, 0);
      if (i == 1) begin
        bus.dbg_req_i   = 1'b0;
        bus.dbg_we_i    = 1'($urandom_range(0, 1));
        bus.dbg_addr_i  = $urandom;
        bus.dbg_wdata_i = $urandom;
      end
    end
    if (we) mem_model[addr] = wdata;
    @(negedge clk);
    bus.mem_ready_i = 1'b0;
    #1;
    chk("dbg_done", bus.dbg_done_o, 1);
    chk("dbg_done_gnt", bus.dbg_gnt_o, 0);
    chk("dbg_done_req", bus.mem_req_o, 0);
    chk("dbg_rdata", bus.dbg_rdata_o, exp_rd);
    @(negedge clk);
    #1;
    chk("dbg_done_pulse", bus.dbg_done_o, 0);
    chk("dbg_rdata_held", bus.dbg_rdata_o, exp_rd);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int          t, lat, k;
    bit          exp_dbg, granted;
    logic [31:0] cpu_a, ra, rv;
    logic        rw, rr;

    mem_model[32'h100] = 32'hDEAD_BEEF;
    mem_model[32'h200] = 32'hCAFE_F00D;
    quiet_inputs();

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", bus.mem_req_o, 0);
    chk("rst_we", bus.mem_we_o, 0);
    chk("rst_addr", bus.mem_addr_o, 0);
    chk("rst_wdata", bus.mem_wdata_o, 0);
    chk("rst_gnt", bus.dbg_gnt_o, 0);
    chk("rst_done", bus.dbg_done_o, 0);
    chk("rst_dbg_rdata", bus.dbg_rdata_o, 0);
    chk("rst_stall", bus.cpu_stall_o, 0);
    reset_n = 1'b1;

    // Plan: load, store, debug read
    cpu_access(1'b1, 1'b0, 32'h100, 32'h0, 1);
    cpu_access(1'b0, 1'b1, 32'h104, 32'h1234_5678, 3);
    dbg_access(1'b0, 32'h200, 32'h0, 2);
    cpu_access(1'b1, 1'b0, 32'h104, 32'h0, 2);

    // Random traffic against the memory model
    for (int n = 0; n < 24; n++) begin
      ra  = 32'h400 + (32'($urandom_range(0, 7)) << 2);
      rv  = $urandom;
      lat = $urandom_range(1, 4);
      rw  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        rr = rw ? 1'($urandom_range(0, 1)) : 1'b1;
        cpu_access(rr, rw, ra, rv, lat);
      end else begin
        dbg_access(rw, ra, rv, lat);
      end
    end

    // Starvation: CPU always busy, debug waits until it has waited STARVE cycles
    t = 0;
    k = 0;
    granted = 1'b0;
    cpu_a = 32'h1000;
    @(negedge clk);
    bus.dbg_req_i  = 1'b1;
    bus.dbg_we_i   = 1'b0;
    bus.dbg_addr_i = 32'h300;
    while (!granted && t < 40) begin
      if (t != 0) @(negedge clk);
      cpu_a = 32'h1000 + 32'(k) * 4;
      bus.cpu_rd_i    = 1'b1;
      bus.cpu_wr_i    = 1'b0;
      bus.cpu_addr_i  = cpu_a;
      bus.mem_ready_i = 1'b0;
      #1;
      chk("starve_idle_stall", bus.cpu_stall_o, 1);
      exp_dbg = (t >= int'(STARVE));
      lat = $urandom_range(1, 3);
      for (int i = 1; i <= lat; i++) begin
        @(negedge clk);
        bus.mem_ready_i = (i == lat);
        bus.mem_rdata_i = model_rd(exp_dbg ? 32'h300 : cpu_a);
        #1;
        chk("starve_gnt", bus.dbg_gnt_o, exp_dbg && i == 1);
        chk("starve_addr", bus.mem_addr_o, exp_dbg ? 32'h300 : cpu_a);
        chk("starve_stall", bus.cpu_stall_o, exp_dbg || i != lat);
        if (exp_dbg && i == 1) bus.dbg_req_i = 1'b0;
      end
      t += 1 + lat;
      if (!exp_dbg) k++;
      granted = exp_dbg;
    end
    chk("starve_granted", 32'(granted), 1);

    // Counter cleared by the grant: same-cycle CPU and debug, CPU wins
    @(negedge clk);
    bus.mem_ready_i = 1'b0;
    bus.dbg_req_i   = 1'b1;
    bus.dbg_we_i    = 1'b1;
    bus.dbg_addr_i  = 32'h304;
    bus.dbg_wdata_i = 32'h0BAD_CAFE;
    #1;
    chk("starve_done", bus.dbg_done_o, 1);
    chk("starve_rdata", bus.dbg_rdata_o, model_rd(32'h300));
    chk("same_idle_stall", bus.cpu_stall_o, 1);
    @(negedge clk);
    bus.mem_ready_i = 1'b1;
    bus.mem_rdata_i = model_rd(cpu_a);
    #1;
    chk("same_cpu_first", bus.mem_addr_o, cpu_a);
    chk("same_no_gnt", bus.dbg_gnt_o, 0);
    chk("same_stall_rel", bus.cpu_stall_o, 0);
    @(negedge clk);
    bus.cpu_rd_i    = 1'b0;
    bus.mem_ready_i = 1'b0;
    #1;
    chk("same_idle_req", bus.mem_req_o, 0);
    rv = $urandom;
    @(negedge clk);
    bus.mem_ready_i = 1'b1;
    bus.mem_rdata_i = rv;
    #1;
    chk("same_dbg_gnt", bus.dbg_gnt_o, 1);
    chk("same_dbg_addr", bus.mem_addr_o, 32'h304);
    chk("same_dbg_we", bus.mem_we_o, 1);
    chk("same_dbg_wdata", bus.mem_wdata_o, 32'h0BAD_CAFE);
    bus.dbg_req_i = 1'b0;
    mem_model[32'h304] = 32'h0BAD_CAFE;
    @(negedge clk);
    bus.mem_ready_i = 1'b0;
    #1;
    chk("same_dbg_done", bus.dbg_done_o, 1);
    chk("same_dbg_rdata", bus.dbg_rdata_o, rv);

    // Reset during CPU_BUSY, then the pending load reissues
    @(negedge clk);
    bus.cpu_rd_i   = 1'b1;
    bus.cpu_addr_i = 32'h100;
    #1;
    @(negedge clk);
    #1;
    chk("rb_req", bus.mem_req_o, 1);
    reset_n = 1'b0;
    #1;
    chk("rmid_req", bus.mem_req_o, 0);
    chk("rmid_addr", bus.mem_addr_o, 0);
    chk("rmid_dbg_rdata", bus.dbg_rdata_o, 0);
    chk("rmid_gnt", bus.dbg_gnt_o, 0);
    chk("rmid_done", bus.dbg_done_o, 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rpost_idle_req", bus.mem_req_o, 0);
    chk("rpost_stall", bus.cpu_stall_o, 1);
    @(negedge clk);
    bus.mem_ready_i = 1'b1;
    bus.mem_rdata_i = model_rd(32'h100);
    #1;
    chk("reissue_req", bus.mem_req_o, 1);
    chk("reissue_addr", bus.mem_addr_o, 32'h100);
    chk("reissue_stall", bus.cpu_stall_o, 0);
    chk("reissue_rdata", bus.cpu_rdata_o, 32'hDEAD_BEEF);
    @(negedge clk);
    bus.cpu_rd_i    = 1'b0;
    bus.mem_ready_i = 1'b0;
    #1;
    chk("reissue_end_req", bus.mem_req_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
